// File: rtl/fwd_hazard_unit_if.sv
// ID-to-hazard-unit bundle: the pipeline controller is the master, the
// forwarding/hazard unit is the slave.
interface fwd_hazard_unit_if #(
    parameter int AW   = 5,
    parameter int NSRC = 2
);
    logic                 id_valid;
    logic [NSRC*AW-1:0]   id_src_addr;
    logic [NSRC-1:0]      id_src_used;
    logic                 id_wr_en;
    logic [AW-1:0]        id_wr_addr;
    logic                 id_is_load;
    logic                 hold;
    logic                 flush;
    logic                 stall;
    logic                 ex_valid;
    logic [2*NSRC-1:0]    ex_fwd_sel;
    // Slot snapshots, packed as {valid, wr_en, wr_addr, is_load}.
    logic [AW+2:0]        dbg_ex;
    logic [AW+2:0]        dbg_mem;
    logic [AW+2:0]        dbg_wb;

    // Flow contract (no valid/ready pair here): the ID instruction is taken
    // into EX on a clock edge where hold=0, flush=0 and stall=0. While stall=1
    // the controller keeps IF/ID unchanged; stall is meaningless while hold=1.
    modport master (
        output id_valid, id_src_addr, id_src_used, id_wr_en, id_wr_addr,
               id_is_load, hold, flush,
        input  stall, ex_valid, ex_fwd_sel, dbg_ex, dbg_mem, dbg_wb
    );

    modport slave (
        input  id_valid, id_src_addr, id_src_used, id_wr_en, id_wr_addr,
               id_is_load, hold, flush,
        output stall, ex_valid, ex_fwd_sel, dbg_ex, dbg_mem, dbg_wb
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use/RAW stall generator using an EX/MEM/WB shadow
// pipeline. Optional statistics counters when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_unit #(
    parameter int AW         = 5,
    parameter int NSRC       = 2,
    parameter int FORWARD_EN = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic               clk,
    input  logic               rst,
    fwd_hazard_unit_if.slave   bus
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]        stat_stall_cnt,
    output logic [31:0]        stat_fwd_mem_cnt,
    output logic [31:0]        stat_fwd_wb_cnt
`endif
);

    typedef struct packed {
        logic          valid;
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic          is_load;
    } slot_t;

    slot_t ex_q, ex_d, mem_q, wb_q;
    logic [2*NSRC-1:0] sel_q, sel_d;
    logic [NSRC-1:0]   m_ex, m_mem, haz;
    logic              advance;

    always_comb begin
        m_ex  = '0;
        m_mem = '0;
        haz   = '0;
        sel_d = '0;
        for (int i = 0; i < NSRC; i++) begin
            // A live operand is one actually read and not the hardwired zero register.
            if (bus.id_src_used[i] &&
                !((ZERO_REG != 0) && (bus.id_src_addr[i*AW +: AW] == '0))) begin
                m_ex[i]  = ex_q.valid && ex_q.wr_en &&
                           (ex_q.wr_addr == bus.id_src_addr[i*AW +: AW]);
                m_mem[i] = mem_q.valid && mem_q.wr_en &&
                           (mem_q.wr_addr == bus.id_src_addr[i*AW +: AW]);
            end
            if (FORWARD_EN != 0) begin
                haz[i] = m_ex[i] && ex_q.is_load;
                if (m_ex[i])
                    sel_d[2*i +: 2] = 2'b10;
                else if (m_mem[i])
                    sel_d[2*i +: 2] = 2'b01;
            end else begin
                haz[i] = m_ex[i] || m_mem[i];
            end
        end
    end

    assign bus.stall = bus.id_valid && !bus.flush && (|haz);
    assign advance   = !bus.flush && !bus.stall;

    always_comb begin
        ex_d = '0;
        if (advance) begin
            ex_d.valid   = bus.id_valid;
            ex_d.wr_en   = bus.id_wr_en;
            ex_d.wr_addr = bus.id_wr_addr;
            ex_d.is_load = bus.id_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            sel_q <= '0;
        end else if (!bus.hold) begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            sel_q <= advance ? sel_d : '0;
        end
    end

    assign bus.ex_valid   = ex_q.valid;
    assign bus.ex_fwd_sel = sel_q;
    assign bus.dbg_ex     = ex_q;
    assign bus.dbg_mem    = mem_q;
    assign bus.dbg_wb     = wb_q;

`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, fwd_mem_cnt_q, fwd_wb_cnt_q;
    logic        any_mem, any_wb;

    always_comb begin
        any_mem = 1'b0;
        any_wb  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel_d[2*i +: 2] == 2'b10) any_mem = 1'b1;
            if (sel_d[2*i +: 2] == 2'b01) any_wb  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            fwd_mem_cnt_q <= '0;
            fwd_wb_cnt_q  <= '0;
        end else if (!bus.hold) begin
            if (bus.stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (advance && any_mem && (fwd_mem_cnt_q != '1))
                fwd_mem_cnt_q <= fwd_mem_cnt_q + 32'd1;
            if (advance && any_wb && (fwd_wb_cnt_q != '1))
                fwd_wb_cnt_q <= fwd_wb_cnt_q + 32'd1;
        end
    end

    assign stat_stall_cnt   = stall_cnt_q;
    assign stat_fwd_mem_cnt = fwd_mem_cnt_q;
    assign stat_fwd_wb_cnt  = fwd_wb_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: one forwarding instance and one
// no-forwarding instance, hand-computed expectations.
module tb_fwd_hazard_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  fwd_hazard_unit_if #(.AW(5), .NSRC(2)) f_if ();
  fwd_hazard_unit_if #(.AW(5), .NSRC(2)) n_if ();

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] f_stall_cnt, f_mem_cnt, f_wb_cnt;
  logic [31:0] n_stall_cnt, n_mem_cnt, n_wb_cnt;
`endif

  fwd_hazard_unit #(.AW(5), .NSRC(2), .FORWARD_EN(1), .ZERO_REG(1)) u_fwd (
    .clk (clk),
    .rst (rst),
    .bus (f_if)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stat_stall_cnt   (f_stall_cnt),
    .stat_fwd_mem_cnt (f_mem_cnt),
    .stat_fwd_wb_cnt  (f_wb_cnt)
`endif
  );

  fwd_hazard_unit #(.AW(5), .NSRC(2), .FORWARD_EN(0), .ZERO_REG(1)) u_nofwd (
    .clk (clk),
    .rst (rst),
    .bus (n_if)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stat_stall_cnt   (n_stall_cnt),
    .stat_fwd_mem_cnt (n_mem_cnt),
    .stat_fwd_wb_cnt  (n_wb_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // driver: tgt=0 drives the forwarding instance, tgt=1 the no-forwarding one
  task automatic drive(input bit tgt, input logic v, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [1:0] used,
                       input logic we, input logic [4:0] wa, input logic ld);
    if (!tgt) begin
      f_if.id_valid = v;  f_if.id_src_addr = {s1, s0}; f_if.id_src_used = used;
      f_if.id_wr_en = we; f_if.id_wr_addr = wa;        f_if.id_is_load = ld;
    end else begin
      n_if.id_valid = v;  n_if.id_src_addr = {s1, s0}; n_if.id_src_used = used;
      n_if.id_wr_en = we; n_if.id_wr_addr = wa;        n_if.id_is_load = ld;
    end
  endtask

  task automatic nop(input bit tgt);
    drive(tgt, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    f_if.hold = 1'b0; f_if.flush = 1'b0;
    n_if.hold = 1'b0; n_if.flush = 1'b0;
    nop(1'b0);
    nop(1'b1);
    tick();
    tick();
    check("reset_stall", f_if.stall, 0);
    check("reset_ex_valid", f_if.ex_valid, 0);
    check("reset_sel", f_if.ex_fwd_sel, 0);
    rst = 1'b0;

    // ALU chain: add r3,r1,r2 ; sub r4,r3,r3
    drive(0, 1, 5'd1, 5'd2, 2'b11, 1, 5'd3, 0);
    settle();
    check("alu_add_stall", f_if.stall, 0);
    tick();
    check("alu_add_ex_valid", f_if.ex_valid, 1);
    check("alu_add_sel", f_if.ex_fwd_sel, 4'b0000);
    drive(0, 1, 5'd3, 5'd3, 2'b11, 1, 5'd4, 0);
    settle();
    check("alu_sub_stall", f_if.stall, 0);
    tick();
    check("alu_sub_ex_valid", f_if.ex_valid, 1);
    check("alu_sub_sel", f_if.ex_fwd_sel, 4'b1010);

    // Two-apart: add r5,r10,r11 ; nop ; and r6,r5,r0
    drive(0, 1, 5'd10, 5'd11, 2'b11, 1, 5'd5, 0);
    tick();
    nop(0);
    tick();
    drive(0, 1, 5'd5, 5'd0, 2'b11, 1, 5'd6, 0);
    settle();
    check("two_apart_stall", f_if.stall, 0);
    tick();
    check("two_apart_sel", f_if.ex_fwd_sel, 4'b0001);

    // Load-use: lw r7,(r12) ; add r8,r7,r1
    drive(0, 1, 5'd12, 5'd0, 2'b01, 1, 5'd7, 1);
    tick();
    drive(0, 1, 5'd7, 5'd1, 2'b11, 1, 5'd8, 0);
    settle();
    check("ld_use_stall_c1", f_if.stall, 1);
    tick();
    check("ld_use_bubble_valid", f_if.ex_valid, 0);
    check("ld_use_bubble_sel", f_if.ex_fwd_sel, 0);
    check("ld_use_stall_c2", f_if.stall, 0);
    tick();
    check("ld_use_ex_valid", f_if.ex_valid, 1);
    check("ld_use_sel", f_if.ex_fwd_sel, 4'b0001);

    // Flush during a pending load-use stall
    drive(0, 1, 5'd12, 5'd0, 2'b01, 1, 5'd7, 1);
    tick();
    drive(0, 1, 5'd7, 5'd1, 2'b11, 1, 5'd8, 0);
    settle();
    check("flush_pre_stall", f_if.stall, 1);
    f_if.flush = 1'b1;
    settle();
    check("flush_stall", f_if.stall, 0);
    tick();
    f_if.flush = 1'b0;
    check("flush_bubble_valid", f_if.ex_valid, 0);
    check("flush_mem_slot", f_if.dbg_mem, 8'b1_1_00111_1);
    nop(0);

    // Hold for 3 cycles with sub in EX and add r3 in MEM
    drive(0, 1, 5'd0, 5'd0, 2'b00, 1, 5'd3, 0);
    tick();
    drive(0, 1, 5'd3, 5'd3, 2'b11, 1, 5'd4, 0);
    tick();
    check("hold_pre_sel", f_if.ex_fwd_sel, 4'b1010);
    f_if.hold = 1'b1;
    nop(0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_ex_valid", f_if.ex_valid, 1);
      check("hold_sel", f_if.ex_fwd_sel, 4'b1010);
      check("hold_mem_slot", f_if.dbg_mem, 8'b1_1_00011_0);
    end
    f_if.hold = 1'b0;
    tick();
    check("resume_ex_valid", f_if.ex_valid, 0);
    check("resume_sel", f_if.ex_fwd_sel, 0);
    check("resume_mem_slot", f_if.dbg_mem, 8'b1_1_00100_0);

    // Async reset mid-stall
    drive(0, 1, 5'd12, 5'd0, 2'b01, 1, 5'd7, 1);
    tick();
    drive(0, 1, 5'd7, 5'd1, 2'b11, 1, 5'd8, 0);
    settle();
    check("rst_pre_stall", f_if.stall, 1);
    check("rst_pre_ex_valid", f_if.ex_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_stall", f_if.stall, 0);
    check("rst_async_ex_valid", f_if.ex_valid, 0);
    check("rst_async_sel", f_if.ex_fwd_sel, 0);
`ifdef FWD_HAZARD_STATS_EN
    check("rst_stat_stall", f_stall_cnt, 0);
    check("rst_stat_mem", f_mem_cnt, 0);
    check("rst_stat_wb", f_wb_cnt, 0);
`endif
    nop(0);
    tick();
    rst = 1'b0;

    // No forwarding: add r2,r1,r1 ; or r9,r2,r2 -> two stall cycles
    drive(1, 1, 5'd1, 5'd1, 2'b11, 1, 5'd2, 0);
    settle();
    check("nofwd_add_stall", n_if.stall, 0);
    tick();
    drive(1, 1, 5'd2, 5'd2, 2'b11, 1, 5'd9, 0);
    settle();
    check("nofwd_stall_c1", n_if.stall, 1);
    tick();
    check("nofwd_stall_c2", n_if.stall, 1);
    check("nofwd_bubble_valid", n_if.ex_valid, 0);
    check("nofwd_sel_c2", n_if.ex_fwd_sel, 0);
    tick();
    check("nofwd_stall_c3", n_if.stall, 0);
    tick();
    check("nofwd_or_ex_valid", n_if.ex_valid, 1);
    check("nofwd_or_sel", n_if.ex_fwd_sel, 0);
    nop(1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational forwarding selector.
- Tracks in-flight register writes across the EX, MEM and WB slots using an internal shadow pipeline.
- Generates load-use stalls and registered per-operand forward selects for the instruction entering EX.
- Supports N source operands, a no-forwarding mode, and flush/hold control from the pipeline controller.

Parameters:
- AW, 5: register address width.
- NSRC, 2: number of source operands per instruction.
- FORWARD_EN, 1:
  - 1: forward from EX/MEM and MEM/WB.
  - 0: no forwarding; stall on every RAW hazard instead.
- ZERO_REG, 1: register 0 is hardwired; it never matches or forwards.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous active-high reset.
- id_valid, input, 1: the ID stage holds a real instruction.
- id_src_addr, input, NSRC*AW: source register addresses; operand i is bits [i*AW +: AW].
- id_src_used, input, NSRC: operand i is actually read.
- id_wr_en, input, 1: the ID instruction writes a register.
- id_wr_addr, input, AW: destination register of the ID instruction.
- id_is_load, input, 1: the ID instruction is a load (result available only from MEM/WB).
- hold, input, 1: global pipeline freeze (e.g. cache miss).
- flush, input, 1: kill the ID instruction; a bubble enters EX.
- stall, output, 1: combinational; hold IF/ID and insert a bubble into EX.
- ex_valid, output, 1: the EX slot holds a real instruction.
- ex_fwd_sel, output, 2*NSRC: registered forward select for operand i in EX, bits [2i+1:2i].
  - 00: register file.
  - 10: EX/MEM result.
  - 01: MEM/WB result.

Behaviour:
- State: three slots (EX, MEM, WB). Each slot holds valid, wr_en, wr_addr and is_load.
- Reset (async, any cycle, including mid-stall):
  - All slots invalid.
  - ex_valid=0, ex_fwd_sel=0.
  - stall is 0 while slots are invalid and id_valid=0.
- match(S,i), for slot S and operand i, is true when all of the following hold:
  - S.valid and S.wr_en;
  - S.wr_addr == src_i;
  - id_src_used[i];
  - src_i != 0, when ZERO_REG=1.
- WB slot never causes a hazard: the register file writes in the first half-cycle and reads in the second.
- haz_i:
  - FORWARD_EN=1: match(EX,i) & EX.is_load.
  - FORWARD_EN=0: match(EX,i) | match(MEM,i).
- stall = id_valid & ~flush & OR(haz_i). stall still evaluates during hold; the controller ignores it while hold=1.
- Per-cycle update priority: rst > hold > flush > stall > advance.
  - hold: all slots and outputs keep their values.
  - flush: EX <= bubble; MEM <= EX; WB <= MEM; ex_fwd_sel <= 0.
  - stall: identical to flush (bubble into EX); the ID instruction is re-evaluated next cycle.
  - advance: EX <= {id_valid, id_wr_en, id_wr_addr, id_is_load}; MEM <= EX; WB <= MEM.
    - FORWARD_EN=1: sel_i <= 10 if match(EX,i); else 01 if match(MEM,i); else 00. EX has priority, being the youngest producer.
    - FORWARD_EN=0: sel_i <= 00 always.
- ex_valid mirrors EX.valid.
- Latency:
  - Forward selects appear one cycle after the consumer is accepted from ID.
  - Load-use costs exactly 1 stall cycle with FORWARD_EN=1.
  - With FORWARD_EN=0, a dependency costs up to 2 stall cycles.
- Multiple operands: each operand is resolved independently. Two operands matching the same producer both get the same select.
- A load in EX whose wr_en=0 never stalls.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- When defined, adds three outputs:
  - stat_stall_cnt, 32-bit: stall cycles, counted only while hold=0.
  - stat_fwd_mem_cnt, 32-bit: advance events with any sel=10.
  - stat_fwd_wb_cnt, 32-bit: advance events with any sel=01.
- Counters clear on rst, saturate at 0xFFFFFFFF, and freeze during hold.
- When undefined: no counters and no extra ports; all other behaviour is identical.

Test Plan:
- ALU chain: add r3 then sub r4,r3,r3 back-to-back, FORWARD_EN=1 -> no stall; in the sub's EX cycle ex_fwd_sel=4'b1010.
- Two-apart: add r5, nop, and r6,r5,r0 -> ex_fwd_sel=4'b0001 in the and's EX cycle; operand with r0 stays 00.
- Load-use: lw r7, then add r8,r7,r1 -> stall=1 for exactly 1 cycle, ex_valid=0 in the bubble, then ex_fwd_sel=4'b0001.
- FORWARD_EN=0: add r2, then or r9,r2,r2 -> stall high for 2 consecutive cycles, ex_fwd_sel stays 0.
- Flush and hold:
  - flush asserted while a load-use stall is pending -> stall=0 and EX receives a bubble.
  - hold for 3 cycles mid-sequence -> slots and outputs unchanged, then resume correctly.
- Reset: assert rst asynchronously mid-stall -> ex_valid, ex_fwd_sel and stall drop immediately. With FWD_HAZARD_STATS_EN defined, the counters read 0.
